// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, functs, ALU ops and control bundle for the single-cycle MIPS core
package mips_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_OR  = 3'd2,
    ALU_SLT = 3'd3,
    ALU_LUI = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic    reg_wr;
    logic    reg_dst;     // 1: write rd, 0: write rt
    logic    link;        // write pc+4 into R31
    logic    alu_src;     // 1: immediate operand
    logic    ext_sign;    // 1: sign-extend imm16, 0: zero-extend
    alu_op_e alu_op;
    logic    mem_wr;
    logic    mem_to_reg;
    logic    branch;
    logic    jump;
    logic    jump_reg;
  } ctrl_t;

endpackage

// File: rtl/ctrl.sv
// rtl/ctrl.sv - combinational instruction decoder; unknown encodings decode as NOP
// jal/jr decode only when JAL_JR_EN is defined.
module ctrl
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctl
);

  always_comb begin
    ctl = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin ctl.reg_wr = 1'b1; ctl.reg_dst = 1'b1; ctl.alu_op = ALU_ADD; end
          FN_SUBU: begin ctl.reg_wr = 1'b1; ctl.reg_dst = 1'b1; ctl.alu_op = ALU_SUB; end
          FN_SLT:  begin ctl.reg_wr = 1'b1; ctl.reg_dst = 1'b1; ctl.alu_op = ALU_SLT; end
`ifdef JAL_JR_EN
          FN_JR:   ctl.jump_reg = 1'b1;
`endif
          default: ;
        endcase
      end
      OP_ORI:  begin ctl.reg_wr = 1'b1; ctl.alu_src = 1'b1; ctl.alu_op = ALU_OR; end
      OP_LUI:  begin ctl.reg_wr = 1'b1; ctl.alu_src = 1'b1; ctl.alu_op = ALU_LUI; end
      OP_ADDI: begin ctl.reg_wr = 1'b1; ctl.alu_src = 1'b1; ctl.ext_sign = 1'b1; end
      OP_LW: begin
        ctl.reg_wr     = 1'b1;
        ctl.alu_src    = 1'b1;
        ctl.ext_sign   = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      OP_SW:   begin ctl.mem_wr = 1'b1; ctl.alu_src = 1'b1; ctl.ext_sign = 1'b1; end
      OP_BEQ:  ctl.branch = 1'b1;
      OP_J:    ctl.jump = 1'b1;
`ifdef JAL_JR_EN
      OP_JAL:  begin ctl.jump = 1'b1; ctl.link = 1'b1; ctl.reg_wr = 1'b1; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath.sv
// rtl/datapath.sv - PC, memories, register file, ALU and next-PC logic of the single-cycle core
module datapath
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_INIT  = 32'h0000_3000,
  parameter int          IM_WORDS = 256,
  parameter int          DM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  ctrl_t       ctl,
  output logic [5:0]  op,
  output logic [5:0]  funct
);

  logic [31:0] pc_q, pc_d, pc_plus4, br_target;
  logic [31:0] instr, rd1, rd2, imm_ext, alu_b, alu_y, dm_dout, wd;
  logic [4:0]  wa;

  pc #(.RESET_VAL(PC_INIT)) u_pc (
    .clk  (clk),
    .rst  (rst),
    .pc_d (pc_d),
    .pc_q (pc_q)
  );

  im_1k #(.IM_WORDS(IM_WORDS)) u_im_1k (
    .clk       (clk),
    .load_en   (1'b0),
    .load_addr (8'h00),
    .load_data (32'h0),
    .addr      (pc_q[9:2]),
    .dout      (instr)
  );

  assign op    = instr[31:26];
  assign funct = instr[5:0];

  gpr u_gpr (
    .clk    (clk),
    .rst    (rst),
    .reg_wr (ctl.reg_wr),
    .ra1    (instr[25:21]),
    .ra2    (instr[20:16]),
    .wa     (wa),
    .wd     (wd),
    .rd1    (rd1),
    .rd2    (rd2)
  );

  // Reset cycles must never commit a store.
  dm_1k #(.DM_BYTES(DM_BYTES)) u_dm_1k (
    .clk  (clk),
    .we   (ctl.mem_wr & ~rst),
    .addr (alu_y[9:0]),
    .din  (rd2),
    .dout (dm_dout)
  );

  always_comb begin
    imm_ext = ctl.ext_sign ? {{16{instr[15]}}, instr[15:0]} : {16'h0, instr[15:0]};
    alu_b   = ctl.alu_src ? imm_ext : rd2;
    case (ctl.alu_op)
      ALU_ADD: alu_y = rd1 + alu_b;
      ALU_SUB: alu_y = rd1 - alu_b;
      ALU_OR:  alu_y = rd1 | alu_b;
      ALU_SLT: alu_y = {31'h0, $signed(rd1) < $signed(alu_b)};
      ALU_LUI: alu_y = {instr[15:0], 16'h0};
      default: alu_y = 32'h0;
    endcase
  end

  always_comb begin
    if (ctl.link)         wa = 5'd31;
    else if (ctl.reg_dst) wa = instr[15:11];
    else                  wa = instr[20:16];

    if (ctl.link)            wd = pc_plus4;
    else if (ctl.mem_to_reg) wd = dm_dout;
    else                     wd = alu_y;
  end

  always_comb begin
    pc_plus4  = pc_q + 32'd4;
    br_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    if (ctl.jump_reg)                    pc_d = rd1;
    else if (ctl.jump)                   pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (ctl.branch && (rd1 == rd2)) pc_d = br_target;
    else                                 pc_d = pc_plus4;
  end

endmodule

// File: rtl/dm_1k.sv
// rtl/dm_1k.sv - 1 KB little-endian byte-addressed data memory, word access only
module dm_1k #(
  parameter int DM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        we,
  input  logic [9:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  logic [7:0] dm [0:DM_BYTES-1];
  logic [7:0] word_idx;
  logic       unused_addr_bits;

  // Word accesses ignore the byte offset.
  assign word_idx         = addr[9:2];
  assign unused_addr_bits = ^addr[1:0];

  always_ff @(posedge clk) begin
    if (we) begin
      dm[{word_idx, 2'b00}] <= din[7:0];
      dm[{word_idx, 2'b01}] <= din[15:8];
      dm[{word_idx, 2'b10}] <= din[23:16];
      dm[{word_idx, 2'b11}] <= din[31:24];
    end
  end

  assign dout = {dm[{word_idx, 2'b11}], dm[{word_idx, 2'b10}],
                 dm[{word_idx, 2'b01}], dm[{word_idx, 2'b00}]};

endmodule

// File: rtl/gpr.sv
// rtl/gpr.sv - 32x32 register file, two async read ports, one sync write port, R0 hardwired to zero
module gpr (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_wr,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] register_file [0:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) register_file[i] <= '0;
    end else if (reg_wr && (wa != 5'd0)) begin
      register_file[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'h0 : register_file[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'h0 : register_file[ra2];

endmodule

// File: rtl/im_1k.sv
// rtl/im_1k.sv - 1 KB word-organised instruction memory, combinational read
module im_1k #(
  parameter int IM_WORDS = 256
) (
  input  logic        clk,
  input  logic        load_en,
  input  logic [7:0]  load_addr,
  input  logic [31:0] load_data,
  input  logic [7:0]  addr,
  output logic [31:0] dout
);

  logic [31:0] im [0:IM_WORDS-1];

  // Load port is tied off in the core; contents normally arrive by backdoor.
  always_ff @(posedge clk) begin
    if (load_en) im[load_addr] <= load_data;
  end

  assign dout = im[addr];

endmodule

// File: rtl/pc.sv
// rtl/pc.sv - program counter register
module pc #(
  parameter logic [31:0] RESET_VAL = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_d,
  output logic [31:0] pc_q
);

  logic [31:0] pc;

  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_VAL;
    else     pc <= pc_d;
  end

  assign pc_q = pc;

endmodule

// File: rtl/mips_single_cycle.sv
// rtl/mips_single_cycle.sv - single-cycle MIPS core top: datapath plus sibling decoder
module mips_single_cycle #(
  parameter logic [31:0] PC_RESET = mips_pkg::PC_RESET,
  parameter int          IM_WORDS = 256,
  parameter int          DM_BYTES = 1024
) (
  input logic clk,
  input logic rst
);

  mips_pkg::ctrl_t ctl;
  logic [5:0]      op;
  logic [5:0]      funct;

  datapath #(
    .PC_INIT  (PC_RESET),
    .IM_WORDS (IM_WORDS),
    .DM_BYTES (DM_BYTES)
  ) u_datapath (
    .clk   (clk),
    .rst   (rst),
    .ctl   (ctl),
    .op    (op),
    .funct (funct)
  );

  ctrl u_ctrl (
    .op    (op),
    .funct (funct),
    .ctl   (ctl)
  );

endmodule

// File: tb/tb_mips_single_cycle.sv
// tb/tb_mips_single_cycle.sv - scoreboard bench: backdoor program, per-instruction expectations
module tb_mips_single_cycle;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mips_single_cycle dut (
    .clk (clk),
    .rst (rst)
  );

  localparam int K_PC = 0, K_GPR = 1, K_DMB = 2, K_RW = 3, K_WE = 4, K_ADDR = 5, K_DIN = 6;

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  function automatic logic [31:0] observe(input int kind, input int idx);
    case (kind)
      K_PC:    return dut.u_datapath.u_pc.pc;
      K_GPR:   return dut.u_datapath.u_gpr.register_file[idx];
      K_DMB:   return {24'h0, dut.u_datapath.u_dm_1k.dm[idx]};
      K_RW:    return {31'h0, dut.u_datapath.u_gpr.reg_wr};
      K_WE:    return {31'h0, dut.u_datapath.u_dm_1k.we};
      K_ADDR:  return {22'h0, dut.u_datapath.u_dm_1k.addr};
      K_DIN:   return dut.u_datapath.u_dm_1k.din;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int kind, input int idx, input logic [31:0] exp);
    sb_entry_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic sb_drain();
    sb_entry_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.kind, e.idx), e.exp);
    end
  endtask

  // Checks the decode-time view, then retires one instruction and checks its effects.
  task automatic step(input string tag, input logic [31:0] pc_exp, input logic rw, input logic mw,
                      input int rd, input logic [31:0] rd_val, input logic [31:0] npc);
    sb_push({tag, ".pc"}, K_PC, 0, pc_exp);
    sb_push({tag, ".reg_wr"}, K_RW, 0, {31'h0, rw});
    sb_push({tag, ".we"}, K_WE, 0, {31'h0, mw});
    sb_drain();
    if (rd >= 0) sb_push({tag, ".rd"}, K_GPR, rd, rd_val);
    sb_push({tag, ".npc"}, K_PC, 0, npc);
    @(posedge clk);
    @(negedge clk);
    sb_drain();
  endtask

  initial begin
    logic [31:0] prog [0:21];
    prog[0]  = enc_i(6'h0D, 0, 1, 16'h1234);
    prog[1]  = enc_i(6'h0F, 0, 2, 16'hABCD);
    prog[2]  = enc_r(1, 2, 3, 6'h21);
    prog[3]  = enc_r(1, 2, 4, 6'h23);
    prog[4]  = enc_i(6'h04, 1, 1, 16'd2);
    prog[5]  = enc_i(6'h0D, 0, 7, 16'hDEAD);
    prog[6]  = enc_i(6'h0D, 0, 7, 16'hBEEF);
    prog[7]  = enc_r(2, 1, 5, 6'h2A);
    prog[8]  = enc_i(6'h0D, 0, 0, 16'd5);
    prog[9]  = enc_i(6'h2B, 0, 3, 16'd4);
    prog[10] = enc_i(6'h23, 0, 6, 16'd4);
    prog[11] = enc_i(6'h04, 1, 2, 16'd5);
    prog[12] = enc_i(6'h08, 1, 8, 16'hFFFF);
    prog[13] = enc_i(6'h23, 0, 9, 16'd7);
    prog[14] = 32'hFC00_0000;
    prog[15] = enc_i(6'h0D, 2, 11, 16'hFFFF);
    prog[16] = enc_j(6'h03, 26'h0C13);
    prog[17] = enc_j(6'h02, 26'h0C15);
    prog[18] = enc_i(6'h0D, 0, 7, 16'd1);
    prog[19] = enc_r(31, 0, 0, 6'h08);
    prog[20] = enc_i(6'h0D, 0, 7, 16'd2);
    prog[21] = enc_j(6'h02, 26'h0C08);
    for (int i = 0; i < 256; i++) dut.u_datapath.u_im_1k.im[i] = 32'h0;
    for (int i = 0; i < 22; i++) dut.u_datapath.u_im_1k.im[i] = prog[i];

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sb_push("rst.pc", K_PC, 0, 32'h0000_3000);
    for (int r = 0; r < 32; r++) sb_push($sformatf("rst.r%0d", r), K_GPR, r, 32'h0);
    sb_drain();
    rst = 1'b0;

    step("ori",    32'h3000, 1'b1, 1'b0, 1,  32'h0000_1234, 32'h3004);
    step("lui",    32'h3004, 1'b1, 1'b0, 2,  32'hABCD_0000, 32'h3008);
    step("addu",   32'h3008, 1'b1, 1'b0, 3,  32'hABCD_1234, 32'h300C);
    step("subu",   32'h300C, 1'b1, 1'b0, 4,  32'h5433_1234, 32'h3010);
    step("beq_t",  32'h3010, 1'b0, 1'b0, -1, 32'h0,         32'h301C);
    step("slt",    32'h301C, 1'b1, 1'b0, 5,  32'h0000_0001, 32'h3020);
    step("ori_r0", 32'h3020, 1'b1, 1'b0, 0,  32'h0,         32'h3024);

    sb_push("sw.addr", K_ADDR, 0, 32'h0000_0004);
    sb_push("sw.din", K_DIN, 0, 32'hABCD_1234);
    step("sw",     32'h3024, 1'b0, 1'b1, -1, 32'h0,         32'h3028);
    sb_push("sw.dm4", K_DMB, 4, 32'h34);
    sb_push("sw.dm5", K_DMB, 5, 32'h12);
    sb_push("sw.dm6", K_DMB, 6, 32'hCD);
    sb_push("sw.dm7", K_DMB, 7, 32'hAB);
    sb_drain();

    step("lw",     32'h3028, 1'b1, 1'b0, 6,  32'hABCD_1234, 32'h302C);
    step("beq_nt", 32'h302C, 1'b0, 1'b0, -1, 32'h0,         32'h3030);
    step("addi",   32'h3030, 1'b1, 1'b0, 8,  32'h0000_1233, 32'h3034);
    step("lw_off", 32'h3034, 1'b1, 1'b0, 9,  32'hABCD_1234, 32'h3038);
    step("op3f",   32'h3038, 1'b0, 1'b0, -1, 32'h0,         32'h303C);
    step("ori_z",  32'h303C, 1'b1, 1'b0, 11, 32'hABCD_FFFF, 32'h3040);
`ifdef JAL_JR_EN
    step("jal",    32'h3040, 1'b1, 1'b0, 31, 32'h0000_3044, 32'h304C);
    step("jr",     32'h304C, 1'b0, 1'b0, -1, 32'h0,         32'h3044);
`else
    step("jal_nop", 32'h3040, 1'b0, 1'b0, 31, 32'h0,        32'h3044);
`endif
    step("j1",     32'h3044, 1'b0, 1'b0, -1, 32'h0,         32'h3054);
    step("j2",     32'h3054, 1'b0, 1'b0, -1, 32'h0,         32'h3020);

    sb_push("end.r7", K_GPR, 7, 32'h0);
    sb_push("end.r0", K_GPR, 0, 32'h0);
    sb_drain();

    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sb_push("rst2.pc", K_PC, 0, 32'h0000_3000);
    sb_push("rst2.r3", K_GPR, 3, 32'h0);
    sb_push("rst2.dm7", K_DMB, 7, 32'hAB);
    sb_drain();
    rst = 1'b0;
    step("post_rst", 32'h3000, 1'b1, 1'b0, 1, 32'h0000_1234, 32'h3004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
